pool2d_stream: RTL and testbench
================================

// Module: pool2d_stream
// PURPOSE
// - Parametrised streaming 2-D pooling layer for the CNN core; successor to the fixed 6x6/2x2 average pool.
// - Consumes one feature-map channel pixel-by-pixel in raster order over a valid/ready stream.
// - Emits the POOLxPOOL, stride-POOL pooled map in raster order; run-time max or average mode.
// - Sits between conv layer output and the next conv/FC stage; no full-frame buffer, one row of partials only.
// PARAMETERS
// - DATA_W   32  signed pixel width, in and out
// - FM_W     6   input map width; must be a multiple of POOL (elaboration $error otherwise)
// - FM_H     6   input map height; must be a multiple of POOL (elaboration $error otherwise)
// - POOL     2   window side = stride; power of two, 2..8 (elaboration $error otherwise)
// PORTS
// - clk        in   1       clock
// - rst_n      in   1       reset; one clock; reset is synchronous and active-low
// - start      in   1       pulse: begin a frame; sampled only in IDLE
// - mode       in   1       0 = average, 1 = max; latched on accepted start
// - in_valid   in   1       input pixel valid
// - in_ready   out  1       block can accept a pixel
// - in_data    in   DATA_W  signed input pixel
// - out_valid  out  1       pooled pixel valid
// - out_ready  in   1       downstream accepts pooled pixel
// - out_data   out  DATA_W  signed pooled pixel
// - busy       out  1       high from accepted start until done
// - done       out  1       one-cycle pulse after last pooled pixel handshakes
// BEHAVIOUR
// - Reset (rst_n low at posedge): state=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0; row/col counters 0.
//   Reset mid-frame aborts the frame; no done pulse; partial-sum contents are don't-care.
// - FSM: IDLE -start-> RUN; RUN -last output handshaked-> DONE; DONE -> IDLE (1 cycle, done=1). start outside IDLE ignored.
// - in_ready = (state==RUN) && !in_last_taken && (!out_valid || out_ready). Pixel accepted on in_valid&&in_ready.
// - Counters: col 0..FM_W-1, row 0..FM_H-1, advance per accepted pixel; wx=col%POOL, wy=row%POOL, ox=col/POOL.
// - Partial buffer part[0..FM_W/POOL-1], width ACC_W = DATA_W + 2*log2(POOL):
//   - wx==0 && wy==0: part[ox] <= sext(px)  (overwrite, no clear pass needed)
//   - otherwise avg: part[ox] <= part[ox] + sext(px); max: part[ox] <= signed max(part[ox], px)
// - Emit when wx==POOL-1 && wy==POOL-1: out_data registered next cycle (latency 1 from accepting last window pixel), out_valid=1.
//   - avg: sum >>> (2*log2(POOL)) arithmetic (floor toward -inf), truncate to DATA_W; no overflow possible.
//   - max: combined value, already DATA_W range.
// - out_valid holds, out_data stable, until out_ready; back-pressure stalls input via in_ready; no pixel lost or duplicated.
// - Same-cycle out handshake and new window completion allowed (out register reloads).
// - Last pixel (row=FM_H-1,col=FM_W-1) accepted -> in_ready=0 until frame ends; DONE entered after final out handshake.
// - Output count per frame exactly (FM_W/POOL)*(FM_H/POOL); mode change mid-frame has no effect.
// STRUCTURE
// - pool_pkg: POOL_AVG/POOL_MAX mode constants, state enum (IDLE/RUN/DONE), acc_w(DATA_W,POOL) function.
// - Sub-module pool_combine: combinational reduce of (part, px, mode, first) -> next partial; instantiated once.
// - Top holds FSM, counters, partial row buffer (FM_W/POOL regs), output register.
// TESTING
// - Default params, avg, input 0..35 raster, out_ready=1 -> outputs 3,5,7,15,17,19,27,29,31 (floor), one done pulse.
// - Same frame, max mode -> 7,9,11,19,21,23,31,33,35.
// - All pixels -1 avg -> all outputs -1; pixels {-1,-2,0,0} per window avg -> -1 (floor of -0.75).
// - FM_W=8,FM_H=4,POOL=4, max, random signed incl. 0x80000000/0x7FFFFFFF -> matches reference model, 2 outputs.
// - out_ready random 30% duty, in_valid random -> stream equals unstalled run; out_data stable while out_valid&&!out_ready.
// - rst_n low after 20 pixels, then restart -> full correct frame, no stale partials, no done on aborted frame; start in RUN ignored.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the streaming 2-D pooling block.
package pool_pkg;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Partial-sum width: room for POOL*POOL signed pixels without overflow.
  function automatic int acc_w(input int data_w, input int pool);
    return data_w + 2 * $clog2(pool);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Combinational reduce of one pixel into a window partial (sum or max).
module pool_combine
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 34
) (
  input  logic signed [ACC_W-1:0]  part,
  input  logic signed [DATA_W-1:0] px,
  input  logic                     mode,
  input  logic                     first,
  output logic signed [ACC_W-1:0]  next
);

  logic signed [ACC_W-1:0] px_ext;

  // First pixel of a window overwrites; later pixels accumulate or compare.
  always_comb begin
    px_ext = {{(ACC_W-DATA_W){px[DATA_W-1]}}, px};
    next   = px_ext;
    if (!first) begin
      if (mode == POOL_MAX) begin
        next = (px_ext > part) ? px_ext : part;
      end else begin
        next = part + px_ext;
      end
    end
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming POOLxPOOL / stride-POOL pooling over one raster-order feature map.
// Holds one row of window partials; emits pooled pixels in raster order.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FM_W   = 6,
  parameter int FM_H   = 6,
  parameter int POOL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int LOG2P = $clog2(POOL);
  localparam int ACC_W = acc_w(DATA_W, POOL);
  localparam int OW    = FM_W / POOL;
  localparam int CW    = (FM_W > 1) ? $clog2(FM_W) : 1;
  localparam int RW    = (FM_H > 1) ? $clog2(FM_H) : 1;
  localparam int OXW   = (OW > 1) ? $clog2(OW) : 1;

  if ((FM_W % POOL) != 0) begin : g_bad_fm_w
    $error("pool2d_stream: FM_W must be a multiple of POOL");
  end
  if ((FM_H % POOL) != 0) begin : g_bad_fm_h
    $error("pool2d_stream: FM_H must be a multiple of POOL");
  end
  if (POOL < 2 || POOL > 8 || (POOL & (POOL - 1)) != 0) begin : g_bad_pool
    $error("pool2d_stream: POOL must be a power of two in 2..8");
  end

  state_t                  state;
  logic                    mode_q;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    last_taken;
  logic signed [ACC_W-1:0] part [OW];

  logic [LOG2P-1:0]        wx, wy;
  logic [OXW-1:0]          ox;
  logic                    first, win_end, last_px, accept;
  logic signed [ACC_W-1:0] part_cur, part_next;
  logic [DATA_W-1:0]       pooled;

  assign in_ready = (state == RUN) && !last_taken && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Window position decode and pooled-value selection for the current pixel.
  always_comb begin
    wx       = col[LOG2P-1:0];
    wy       = row[LOG2P-1:0];
    ox       = OXW'(col >> LOG2P);
    first    = (wx == '0) && (wy == '0);
    win_end  = (wx == LOG2P'(POOL - 1)) && (wy == LOG2P'(POOL - 1));
    last_px  = (col == CW'(FM_W - 1)) && (row == RW'(FM_H - 1));
    part_cur = part[ox];
    // Taking the DATA_W bits above the 2*log2(POOL) LSBs is the arithmetic
    // right shift (floor) followed by truncation.
    pooled   = (mode_q == POOL_MAX) ? part_next[DATA_W-1:0]
                                    : part_next[2*LOG2P +: DATA_W];
  end

  pool_combine #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_combine (
    .part (part_cur),
    .px   (in_data),
    .mode (mode_q),
    .first(first),
    .next (part_next)
  );

  // Row of window partials; contents are don't-care across reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      part[ox] <= part_next;
    end
  end

  // Frame FSM, raster counters and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= POOL_AVG;
      col        <= '0;
      row        <= '0;
      last_taken <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            mode_q     <= mode;
            col        <= '0;
            row        <= '0;
            last_taken <= 1'b0;
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (last_taken) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          if (accept) begin
            if (col == CW'(FM_W - 1)) begin
              col <= '0;
              row <= (row == RW'(FM_H - 1)) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_px) begin
              last_taken <= 1'b1;
            end
            if (win_end) begin
              out_valid <= 1'b1;
              out_data  <= pooled;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Randomised self-checking bench for pool2d_stream: two instances
// (6x6/2x2 and 8x4/4x4) against a window-arithmetic reference model.
module tb_pool2d_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [31:0] in_data = '0;

  logic in_ready_a, out_valid_a, busy_a, done_a;
  logic in_ready_b, out_valid_b, busy_b, done_b;
  logic [31:0] out_data_a, out_data_b;

  logic sel = 1'b0;
  logic c_in_ready, c_out_valid, c_busy, c_done;
  logic signed [31:0] c_out_data;

  logic signed [31:0] pix[$];
  logic signed [31:0] expq[$];
  logic signed [31:0] got[$];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pool2d_stream dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .done(done_a)
  );

  pool2d_stream #(.DATA_W(32), .FM_W(8), .FM_H(4), .POOL(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .done(done_b)
  );

  always_comb begin
    c_in_ready  = sel ? in_ready_b  : in_ready_a;
    c_out_valid = sel ? out_valid_b : out_valid_a;
    c_out_data  = sel ? out_data_b  : out_data_a;
    c_busy      = sel ? busy_b      : busy_a;
    c_done      = sel ? done_b      : done_a;
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: each window pooled with exact arithmetic (floor division for average).
  function automatic void model(input int w, input int h, input int p, input bit md);
    longint sum, mx, v, q, n;
    expq.delete();
    n = longint'(p * p);
    for (int oy = 0; oy < h / p; oy++) begin
      for (int ox = 0; ox < w / p; ox++) begin
        sum = 0;
        mx  = longint'(pix[(oy * p) * w + ox * p]);
        for (int dy = 0; dy < p; dy++) begin
          for (int dx = 0; dx < p; dx++) begin
            v = longint'(pix[(oy * p + dy) * w + ox * p + dx]);
            sum += v;
            if (v > mx) mx = v;
          end
        end
        q = sum / n;
        if ((sum % n) != 0 && sum < 0) q = q - 1;
        expq.push_back(md ? 32'(mx) : 32'(q));
      end
    end
  endfunction

  function automatic void fill_random(input int count);
    pix.delete();
    for (int i = 0; i < count; i++) pix.push_back(32'($urandom));
    pix[1] = 32'h8000_0000;
    pix[3] = 32'h7FFF_FFFF;
    pix[count - 2] = 32'h8000_0000;
  endfunction

  task automatic run_frame(input bit b, input bit md, input int pin, input int pout,
                           input string name);
    int idx, cyc, tail, viol, dn, w, h, p;
    bit hold;
    logic signed [31:0] hold_data;
    w = b ? 8 : 6;
    h = b ? 4 : 6;
    p = b ? 4 : 2;
    model(w, h, p, md);
    got.delete();
    idx = 0; cyc = 0; tail = 0; viol = 0; dn = 0; hold = 0; hold_data = '0;
    @(negedge clk);
    sel = b; mode = md; start_a = !b; start_b = b;
    @(negedge clk);
    start_a = 0; start_b = 0; mode = !md;
    #1 check({name, ":busy"}, 64'(c_busy), 1);
    while (cyc < 4000 && tail < 3) begin
      if (b) start_b = (cyc == 5); else start_a = (cyc == 5);
      in_valid  = (idx < pix.size()) && (int'($urandom_range(99)) < pin);
      in_data   = in_valid ? pix[idx] : 32'($urandom);
      out_ready = int'($urandom_range(99)) < pout;
      #1;
      if (hold && !(c_out_valid && c_out_data == hold_data)) viol++;
      hold = c_out_valid && !out_ready;
      hold_data = c_out_data;
      if (c_done) dn++;
      if (dn > 0) tail++;
      if (c_out_valid && out_ready) got.push_back(c_out_data);
      if (in_valid && c_in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start_a = 0; start_b = 0; in_valid = 0; out_ready = 0;
    #1;
    check({name, ":timeout"}, 64'(cyc < 4000), 1);
    check({name, ":done_pulses"}, dn, 1);
    check({name, ":consumed"}, idx, pix.size());
    check({name, ":out_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("%s:out%0d", name, i), got[i], expq[i]);
    check({name, ":stable_under_stall"}, viol, 0);
    check({name, ":busy_after"}, 64'(c_busy), 0);
    check({name, ":in_ready_after"}, 64'(c_in_ready), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, ":in_ready"},  64'(in_ready_a), 0);
    check({name, ":out_valid"}, 64'(out_valid_a), 0);
    check({name, ":out_data"},  64'(out_data_a), 0);
    check({name, ":busy"},      64'(busy_a), 0);
    check({name, ":done"},      64'(done_a), 0);
    check({name, ":b_busy"},    64'(busy_b), 0);
  endtask

  task automatic abort_frame();
    int idx, cyc, dn;
    idx = 0; cyc = 0; dn = 0;
    fill_random(36);
    @(negedge clk);
    sel = 0; mode = 1; start_a = 1;
    @(negedge clk);
    start_a = 0;
    while (idx < 20 && cyc < 200) begin
      in_valid = 1; in_data = pix[idx]; out_ready = 1;
      #1;
      if (c_done) dn++;
      if (c_in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check("abort:fed", idx, 20);
    check("abort:no_done", dn, 0);
    check_reset("abort");
    repeat (3) begin
      @(negedge clk);
      #1 check("abort:no_done_after", 64'(done_a), 0);
    end
  endtask

  initial begin
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    rst_n = 1;

    pix.delete();
    for (int i = 0; i < 36; i++) pix.push_back(32'(i));
    run_frame(0, 0, 100, 100, "avg_ramp");
    run_frame(0, 1, 100, 100, "max_ramp");

    pix.delete();
    for (int i = 0; i < 36; i++) pix.push_back(-32'sd1);
    run_frame(0, 0, 100, 100, "avg_neg1");

    pix.delete();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        pix.push_back((r % 2 == 0) ? ((c % 2 == 0) ? -32'sd1 : -32'sd2) : 32'sd0);
    run_frame(0, 0, 100, 100, "avg_floor");

    fill_random(32);
    run_frame(1, 1, 100, 100, "b_max_rand");
    fill_random(32);
    run_frame(1, 0, 100, 100, "b_avg_rand");

    fill_random(36);
    run_frame(0, 0, 60, 30, "stall_avg");
    fill_random(36);
    run_frame(0, 1, 60, 30, "stall_max");
    fill_random(32);
    run_frame(1, 0, 50, 30, "b_stall_avg");

    abort_frame();
    fill_random(36);
    run_frame(0, 0, 70, 50, "restart_avg");
    pix.delete();
    for (int i = 0; i < 36; i++) pix.push_back(32'(i));
    run_frame(0, 1, 100, 100, "restart_max");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
